// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between a read-only
// fetch port and a read/write data port; one request outstanding at a time.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_valid_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_dm_q, last_dm_d;
  logic              owner_dm_q, owner_dm_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_if, grant_dm;
  logic [DATA_W-1:0] capture;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (if_valid_i && (!dm_valid_i || last_dm_q)) begin
        grant_if = 1'b1;
      end else if (dm_valid_i) begin
        grant_dm = 1'b1;
      end
    end
  end

  assign capture = mem_we_q ? '0 : mem_rdata_i;

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    owner_dm_d  = owner_dm_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          mem_addr_d  = if_addr_i;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          owner_dm_d  = 1'b0;
          last_dm_d   = 1'b0;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else if (grant_dm) begin
          mem_addr_d  = dm_addr_i;
          mem_we_d    = dm_we_i;
          mem_wdata_d = dm_wdata_i;
          owner_dm_d  = 1'b1;
          last_dm_d   = 1'b1;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (owner_dm_q) begin
            dm_rdata_d  = capture;
            dm_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = capture;
            if_rvalid_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b1;
      owner_dm_q  <= 1'b0;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      owner_dm_q  <= owner_dm_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ready_o  = grant_if;
  assign dm_ready_o  = grant_dm;
  assign if_rvalid_o = if_rvalid_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
